// File: rtl/fifo_tx_drain_pkg.sv
// Shared definitions for the FIFO-to-transmitter drain block.
package fifo_tx_drain_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_tx_drain_if.sv
// FIFO read-port and transmitter handshake bundle seen by the drain block.
interface fifo_tx_drain_if
  import fifo_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  ack_err;
  logic                  drain_idle;

  // master: the drain block itself; slave: FIFO read side plus transmitter
  modport master (
    input  rempty, rdata, tx_busy,
    output rinc, tx_data, tx_valid, ack_err, drain_idle
  );

  modport slave (
    output rempty, rdata, tx_busy,
    input  rinc, tx_data, tx_valid, ack_err, drain_idle
  );

endinterface

// File: rtl/fifo_tx_drain.sv
// Pops one FIFO word whenever the transmitter is idle, strobes it out for one
// cycle and follows the busy handshake to completion before the next pop.
module fifo_tx_drain
  import fifo_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_tx_drain_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t                state;
  logic [CNT_W-1:0]      ack_cnt;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  ack_err_q;
  logic                  pop;

  // Busy wins over a freshly non-empty FIFO; reset also masks the pop.
  assign pop = (state == ST_IDLE) & ~bus.rempty & ~bus.tx_busy & rrst_n;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= ST_IDLE;
      ack_cnt    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q  <= bus.rdata;
            tx_valid_q <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_valid_q <= 1'b0;
          ack_cnt    <= '0;
          state      <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Compared before increment, so the counter never wraps.
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (ack_cnt == CNT_LAST) begin
            ack_err_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rinc       = pop;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.drain_idle = (state == ST_IDLE) & bus.rempty;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Directed and randomized bench for fifo_tx_drain against a cycle-offset
// handshake model with a queue standing in for the async FIFO.
module tb_fifo_tx_drain;

  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 5;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  fifo_tx_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_tx_drain #(
    .DATA_WIDTH (DW),
    .ACK_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model of the drain handshake
  logic [DW-1:0] fifo_q[$];
  bit            m_ready = 1'b1;
  int            m_age   = 99;
  bit            m_acked = 1'b0;
  bit            m_err   = 1'b0;
  logic [DW-1:0] m_last  = '0;

  // Transmitter: either manual busy level, or busy for resp_hold cycles after each strobe
  bit resp_mode = 1'b0;
  int resp_hold = 0;
  int resp_cnt  = 0;
  bit busy_man  = 1'b0;
  bit rst_drive = 1'b0;

  int            cyc       = 0;
  int            n_pops    = 0;
  int            n_valids  = 0;
  int            valid_cyc = -1;
  logic [DW-1:0] valid_word = '0;
  bit            s_ack     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b1;
    m_age   = 99;
    m_acked = 1'b0;
    m_err   = 1'b0;
    m_last  = '0;
  endtask

  // One rclk cycle: drive at the falling edge, check mid-low phase, advance the model.
  task automatic cycle();
    bit busy;
    bit exp_rinc;
    @(negedge rclk);
    rrst_n      = rst_drive;
    busy        = resp_mode ? (resp_cnt > 0) : busy_man;
    bus.tx_busy = busy;
    bus.rempty  = (fifo_q.size() == 0);
    bus.rdata   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    #2;
    exp_rinc = rrst_n && m_ready && (fifo_q.size() > 0) && !busy;
    chk("rinc",       32'(bus.rinc),       32'(exp_rinc));
    chk("tx_valid",   32'(bus.tx_valid),   32'(m_age == 1));
    chk("tx_data",    32'(bus.tx_data),    32'(m_last));
    chk("ack_err",    32'(bus.ack_err),    32'(m_err));
    chk("drain_idle", 32'(bus.drain_idle), 32'(m_ready && fifo_q.size() == 0));
    if (bus.rinc) n_pops++;
    if (bus.tx_valid) begin
      n_valids++;
      valid_word = bus.tx_data;
      valid_cyc  = cyc;
    end
    s_ack = bus.ack_err;
    if (!rrst_n) begin
      model_reset();
    end else if (exp_rinc) begin
      m_last  = fifo_q.pop_front();
      m_ready = 1'b0;
      m_age   = 1;
      m_acked = 1'b0;
    end else begin
      // age 1 is the strobe cycle; ages 2..TO+1 are the acknowledge window
      if (!m_ready && m_age >= 2) begin
        if (m_acked) begin
          if (!busy) m_ready = 1'b1;
        end else if (busy) begin
          m_acked = 1'b1;
        end else if (m_age == TO + 1) begin
          m_err   = 1'b1;
          m_ready = 1'b1;
        end
      end
      if (m_age < 99) m_age++;
    end
    if (resp_mode) begin
      if (bus.tx_valid) resp_cnt = resp_hold;
      else if (resp_cnt > 0) resp_cnt--;
    end
    cyc++;
  endtask

  initial begin
    int p0;
    int v0;
    int ent;
    bus.rempty  = 1'b1;
    bus.rdata   = '0;
    bus.tx_busy = 1'b0;

    // Reset held with a word waiting, then the first pop and strobe
    fifo_q.push_back(8'hA5);
    resp_mode = 1'b1;
    resp_hold = 2;
    rst_drive = 1'b0;
    repeat (3) cycle();
    rst_drive = 1'b1;
    p0 = n_pops;
    v0 = n_valids;
    cycle();
    chk("t1_first_pop", 32'(n_pops - p0), 32'd1);
    cycle();
    chk("t1_first_valid", 32'(n_valids - v0), 32'd1);
    chk("t1_word", 32'(valid_word), 32'hA5);
    repeat (10) cycle();

    // Three words, busy held 10 cycles after each strobe
    p0 = n_pops;
    v0 = n_valids;
    resp_hold = 10;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    repeat (60) cycle();
    chk("t2_pops", 32'(n_pops - p0), 32'd3);
    chk("t2_valids", 32'(n_valids - v0), 32'd3);
    chk("t2_last_word", 32'(valid_word), 32'h33);
    chk("t2_drain_idle", 32'(bus.drain_idle), 32'd1);

    // Transmitter occupied by someone else: no pop until busy falls
    resp_mode = 1'b0;
    busy_man  = 1'b1;
    fifo_q.push_back(8'h5C);
    p0 = n_pops;
    repeat (20) cycle();
    chk("t3_no_pop_busy", 32'(n_pops - p0), 32'd0);
    busy_man = 1'b0;
    cycle();
    chk("t3_pop_after_fall", 32'(n_pops - p0), 32'd1);
    resp_mode = 1'b1;
    resp_hold = 1;
    repeat (8) cycle();

    // No acknowledge at all: timeout and sticky error
    resp_hold = 0;
    fifo_q.push_back(8'h77);
    v0 = n_valids;
    for (int i = 0; i < 10 && n_valids == v0; i++) cycle();
    chk("t4_valid_seen", 32'(n_valids - v0), 32'd1);
    ent = valid_cyc + 1;
    for (int i = 0; i < 40 && !s_ack; i++) cycle();
    chk("t4_timeout_cycles", 32'(cyc - 1 - ent), 32'(TO));
    resp_hold = 3;
    fifo_q.push_back(8'h88);
    p0 = n_pops;
    repeat (15) cycle();
    chk("t4_next_pop", 32'(n_pops - p0), 32'd1);
    chk("t4_next_word", 32'(valid_word), 32'h88);
    chk("t4_err_sticky", 32'(bus.ack_err), 32'd1);

    // Asynchronous reset while waiting for busy to finish
    resp_hold = 8;
    fifo_q.push_back(8'h9A);
    fifo_q.push_back(8'h9B);
    v0 = n_valids;
    for (int i = 0; i < 10 && n_valids == v0; i++) cycle();
    chk("t5_valid_seen", 32'(n_valids - v0), 32'd1);
    repeat (4) cycle();
    @(posedge rclk);
    #3;
    rrst_n    = 1'b0;
    rst_drive = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.tx_valid), 32'd0);
    chk("t5_async_err", 32'(bus.ack_err), 32'd0);
    chk("t5_async_data", 32'(bus.tx_data), 32'd0);
    chk("t5_async_rinc", 32'(bus.rinc), 32'd0);
    model_reset();
    resp_cnt = 0;
    repeat (2) cycle();
    rst_drive = 1'b1;
    p0 = n_pops;
    repeat (15) cycle();
    chk("t5_one_pop", 32'(n_pops - p0), 32'd1);
    chk("t5_word", 32'(valid_word), 32'h9B);

    // Empty FIFO with a toggling transmitter
    resp_mode = 1'b0;
    p0 = n_pops;
    v0 = n_valids;
    repeat (20) begin
      busy_man = ~busy_man;
      cycle();
    end
    chk("t6_no_pop", 32'(n_pops - p0), 32'd0);
    chk("t6_no_valid", 32'(n_valids - v0), 32'd0);
    chk("t6_drain_idle", 32'(bus.drain_idle), 32'd1);

    // Randomized traffic and busy pattern
    repeat (800) begin
      busy_man = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) fifo_q.push_back(DW'($urandom));
      cycle();
    end
    for (int i = 0; i < 3000 && (fifo_q.size() > 0 || !m_ready); i++) begin
      busy_man = ($urandom_range(0, 1) == 1);
      cycle();
    end
    chk("rnd_drained", 32'(fifo_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
